sram_access_controller: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_read_buffer.sv | 41 ++++
 rtl/sram_access_controller.sv | 118 +++++++++++
 tb/tb_sram_access_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types, default geometry and address translation for the SRAM controller
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int SRAM_ADDR_W      = 17;
   localparam int SRAM_DATA_W      = 32;
   localparam int SRAM_WAIT_CYCLES = 5;
   localparam int SRAM_ADDR_BASE   = 1024;

   // Byte address relative to the SRAM window, as a word index; caller truncates to its width.
   function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr, input logic [31:0] base);
      return (byte_addr - base) >> 2;
   endfunction

endpackage

// File: rtl/sram_read_buffer.sv
// rtl/sram_read_buffer.sv - one-entry {valid, word address, data} cache of the last completed read
module sram_read_buffer
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              fill,
   input  logic [ADDR_W-1:0] fill_addr,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              inval,
   input  logic [ADDR_W-1:0] inval_addr,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data
);

   logic              valid;
   logic [ADDR_W-1:0] tag;
   logic [DATA_W-1:0] data;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else if (fill) begin
         valid <= 1'b1;
         tag   <= fill_addr;
         data  <= fill_data;
      end else if (inval && inval_addr == tag) begin
         valid <= 1'b0;
      end
   end

   assign hit      = valid && (lookup_addr == tag);
   assign hit_data = data;

endmodule

// File: rtl/sram_access_controller.sv
// rtl/sram_access_controller.sv - multi-cycle MEM-stage to SRAM sequencer; optional read buffer under SRAM_READ_BUF_EN
module sram_access_controller
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W      = SRAM_ADDR_W,
   parameter int DATA_W      = SRAM_DATA_W,
   parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
   parameter int ADDR_BASE   = SRAM_ADDR_BASE
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic              SRAM_WE_N
);

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t            state;
   logic [3:0]        cnt;
   logic              op_write;
   logic              dq_oe;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] word_addr;
   logic              req;
   logic              hit;
   logic [DATA_W-1:0] buf_hit_data;

   assign word_addr = ADDR_W'(byte_to_word(addr, 32'(ADDR_BASE)));
   assign req       = mem_r_en | mem_w_en;

`ifdef SRAM_READ_BUF_EN
   logic lookup_hit;

   sram_read_buffer #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_read_buffer (
      .clk         (clk),
      .rst         (rst),
      .fill        (state == ACCESS && !op_write && cnt == LAST_CNT),
      .fill_addr   (SRAM_ADDR),
      .fill_data   (SRAM_DQ),
      .inval       (state == IDLE && mem_w_en),
      .inval_addr  (word_addr),
      .lookup_addr (word_addr),
      .hit         (lookup_hit),
      .hit_data    (buf_hit_data)
   );

   // A hit is served entirely in IDLE; both-high requests are writes, so never hits.
   assign hit   = !rst && (state == IDLE) && mem_r_en && !mem_w_en && lookup_hit;
   assign rdata = hit ? buf_hit_data : rdata_q;
`else
   assign hit          = 1'b0;
   assign buf_hit_data = '0;
   assign rdata        = rdata_q;
`endif

   // Combinational in IDLE so the pipeline freezes in the very cycle the request appears.
   assign ready = rst | ((state == IDLE) ? (~req | hit) : (state == DONE));

   assign SRAM_DQ = dq_oe ? wdata_q : {DATA_W{1'bz}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op_write  <= 1'b0;
         dq_oe     <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         SRAM_ADDR <= '0;
         SRAM_WE_N <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  rdata_q <= buf_hit_data;
               end else if (req) begin
                  op_write  <= mem_w_en;
                  SRAM_ADDR <= word_addr;
                  wdata_q   <= wdata;
                  cnt       <= '0;
                  SRAM_WE_N <= ~mem_w_en;
                  dq_oe     <= mem_w_en;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               cnt <= cnt + 4'd1;
               if (cnt == LAST_CNT) begin
                  SRAM_WE_N <= 1'b1;
                  dq_oe     <= 1'b0;
                  if (!op_write) begin
                     rdata_q <= SRAM_DQ;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_access_controller.sv
// tb/tb_sram_access_controller.sv - directed and random accesses against a behavioural SRAM/controller model
module tb_sram_access_controller;

   localparam int WAIT = 5;
`ifdef SRAM_READ_BUF_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_r_en = 1'b0;
   logic        mem_w_en = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        ready;
   logic [16:0] SRAM_ADDR;
   wire  [31:0] sram_dq;
   logic        SRAM_WE_N;

   logic        sram_oe = 1'b0;
   logic [31:0] sram_mem [0:131071];

   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] last_rdata = 32'd0;
   bit          buf_valid = 1'b0;
   logic [31:0] buf_word = 32'd0;

   int n_assert = 0;
   int n_fail   = 0;

   sram_access_controller dut (
      .clk       (clk),
      .rst       (rst),
      .mem_r_en  (mem_r_en),
      .mem_w_en  (mem_w_en),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DQ   (sram_dq),
      .SRAM_WE_N (SRAM_WE_N)
   );

   always #5 clk = ~clk;

   // External SRAM: drives the bus only while the bench has a read outstanding.
   assign sram_dq = (sram_oe && SRAM_WE_N === 1'b1) ? sram_mem[SRAM_ADDR] : 32'bz;
   always @(posedge clk) if (SRAM_WE_N === 1'b0) sram_mem[SRAM_ADDR] <= sram_dq;

   wire dq_float = (sram_dq === 32'bz);

   function automatic logic [31:0] init_word(input logic [31:0] w);
      return 32'h5A00_0000 ^ (w * 32'h0000_9E37);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b0; sram_oe = 1'b0;
      #3;
      chk("idle_ready", 32'(ready), 32'd1);
   endtask

   task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output int freeze);
      logic [31:0] w;
      logic [31:0] exp_data;
      bit          hit;
      int          exp_freeze;
      w          = ((a - 32'd1024) >> 2) % 32'd131072;
      hit        = BUF_EN && !wr && buf_valid && (buf_word == w);
      exp_freeze = hit ? 0 : WAIT + 1;
      @(posedge clk); #1;
      mem_r_en = rd; mem_w_en = wr; addr = a; wdata = d; sram_oe = !wr;
      freeze = 0;
      #3;
      while (ready !== 1'b1 && freeze < 40) begin
         freeze++;
         @(posedge clk); #1;
         addr = $urandom; wdata = $urandom;
         #3;
         if (ready !== 1'b1) begin
            chk("access_addr", 32'(SRAM_ADDR), w);
            chk("access_we_n", 32'(SRAM_WE_N), 32'(!wr));
            if (wr) chk("access_dq", sram_dq, d);
         end
      end
      chk("freeze_cycles", 32'(freeze), 32'(exp_freeze));
      chk("done_we_n", 32'(SRAM_WE_N), 32'd1);
      if (wr) begin
         chk("done_dq_z", 32'(dq_float), 32'd1);
         chk("rdata_hold", rdata, last_rdata);
         ref_mem[w] = d;
         if (buf_valid && buf_word == w) buf_valid = 1'b0;
      end else begin
         exp_data = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
         chk("read_data", rdata, exp_data);
         last_rdata = exp_data;
         buf_valid  = 1'b1;
         buf_word   = w;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f1, f2, k;
      bit wr;
      logic [31:0] a;
      for (int i = 0; i < 131072; i++) sram_mem[i] = init_word(32'(i));

      // Reset held two cycles with a read request pending.
      mem_r_en = 1'b1; addr = 32'd1032;
      repeat (2) @(posedge clk);
      #4;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
      chk("rst_dq_z", 32'(dq_float), 32'd1);
      chk("rst_sram_addr", 32'(SRAM_ADDR), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      #1;
      rst = 1'b0; mem_r_en = 1'b0;

      access(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, f1);
      access(1'b1, 1'b0, 32'd1032, 32'd0, f1);
      chk("readback_deadbeef", rdata, 32'hDEAD_BEEF);
      idle();

      access(1'b0, 1'b1, 32'd1024, 32'h1234_5678, f1);
      access(1'b1, 1'b0, 32'd1028, 32'd0, f2);
      chk("b2b_total_freeze", 32'(f1 + f2), 32'd12);
      idle();

      access(1'b1, 1'b1, 32'd1036, 32'hCAFE_F00D, f1);
      access(1'b1, 1'b0, 32'd1036, 32'd0, f1);
      access(1'b0, 1'b1, 32'd1020, 32'h0BAD_CAFE, f1);
      access(1'b1, 1'b0, 32'd1020, 32'd0, f1);
      idle();

      access(1'b1, 1'b0, 32'd1040, 32'd0, f1);
      access(1'b1, 1'b0, 32'd1040, 32'd0, f2);
      chk("repeat_read_freeze", 32'(f2), BUF_EN ? 32'd0 : 32'd6);
      access(1'b0, 1'b1, 32'd1040, 32'h7777_AAAA, f1);
      access(1'b1, 1'b0, 32'd1040, 32'd0, f2);
      chk("read_after_write_freeze", 32'(f2), 32'd6);
      idle();

      // Reset in the third ACCESS cycle of a write.
      @(posedge clk); #1;
      mem_w_en = 1'b1; addr = 32'd1424; wdata = 32'h5555_5555;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #3;
      chk("midrst_ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0; mem_w_en = 1'b0;
      #3;
      chk("midrst_we_n", 32'(SRAM_WE_N), 32'd1);
      chk("midrst_dq_z", 32'(dq_float), 32'd1);
      chk("midrst_ready_idle", 32'(ready), 32'd1);
      chk("midrst_rdata", rdata, 32'd0);
      last_rdata = 32'd0;
      buf_valid  = 1'b0;

      for (int i = 0; i < 24; i++) begin
         wr = 1'($urandom_range(0, 1));
         k  = int'($urandom_range(0, 8));
         a  = (k == 8) ? 32'd1020 : 32'd1024 + 32'(4 * k);
         a  = a + 32'($urandom_range(0, 3));
         access(!wr, wr, a, $urandom, f1);
         if ($urandom_range(0, 2) == 0) idle();
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
